// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares the memory port between fetch and dcache and routes responses by tag ownership
module mem_arbiter #(
   parameter  int NUM_MEM_TAGS          = 15,
   parameter  int STARVE_LIMIT          = 4,
   parameter  int FETCH_MAX_OUTSTANDING = 8,
   parameter  int ADDR_W                = 32,
   parameter  int BLOCK_W               = 64,
   localparam int TAG_W                 = $clog2(NUM_MEM_TAGS + 1),
   localparam int SC_W                  = $clog2(STARVE_LIMIT + 1)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               fetch_en,
   input  logic [ADDR_W-1:0]  fetch_addr,
   output logic               fetch_grant,
   output logic [TAG_W-1:0]   fetch_trans_tag,
   output logic [TAG_W-1:0]   fetch_data_tag,
   input  logic               dcache_en,
   input  logic [1:0]         dcache_cmd,
   input  logic [ADDR_W-1:0]  dcache_addr,
   input  logic [BLOCK_W-1:0] dcache_wdata,
   output logic               dcache_grant,
   output logic [TAG_W-1:0]   dcache_trans_tag,
   output logic [TAG_W-1:0]   dcache_data_tag,
   output logic [BLOCK_W-1:0] resp_data,
   output logic [1:0]         proc2mem_command,
   output logic [ADDR_W-1:0]  proc2mem_addr,
   output logic [BLOCK_W-1:0] proc2mem_data,
   input  logic [TAG_W-1:0]   mem2proc_transaction_tag,
   input  logic [TAG_W-1:0]   mem2proc_data_tag,
   input  logic [BLOCK_W-1:0] mem2proc_data,
   output logic [TAG_W-1:0]   fetch_outstanding
);

   localparam logic [1:0] MEM_NONE  = 2'd0;
   localparam logic [1:0] MEM_LOAD  = 2'd1;
   localparam logic [1:0] MEM_STORE = 2'd2;

   // Table spans every encodable tag so any nonzero tag indexes in range.
   localparam int NUM_SLOTS = (2 ** TAG_W) - 1;

   logic [NUM_SLOTS:1] owner_valid;
   logic [NUM_SLOTS:1] owner_is_fetch;
   logic [SC_W-1:0]    starve_cnt;

   logic starve_force;
   logic fetch_issue;
   logic accepted;
   logic alloc;
   logic resp_hit;
   logic resp_fetch;

   assign starve_force = (starve_cnt == SC_W'(STARVE_LIMIT));
   assign dcache_grant = dcache_en & ~starve_force;
   assign fetch_grant  = ~dcache_grant & (fetch_outstanding < TAG_W'(FETCH_MAX_OUTSTANDING));
   assign fetch_issue  = fetch_grant & fetch_en;

   always_comb begin
      proc2mem_command = MEM_NONE;
      proc2mem_addr    = '0;
      proc2mem_data    = '0;
      if (dcache_grant) begin
         proc2mem_command = dcache_cmd;
         proc2mem_addr    = dcache_addr;
         proc2mem_data    = dcache_wdata;
      end else if (fetch_issue) begin
         proc2mem_command = MEM_LOAD;
         proc2mem_addr    = fetch_addr;
      end
   end

   assign accepted = (proc2mem_command != MEM_NONE) && (mem2proc_transaction_tag != '0);
   assign alloc    = accepted && (proc2mem_command == MEM_LOAD);

   assign fetch_trans_tag  = fetch_grant  ? mem2proc_transaction_tag : '0;
   assign dcache_trans_tag = dcache_grant ? mem2proc_transaction_tag : '0;

   assign resp_hit   = (mem2proc_data_tag != '0) && owner_valid[mem2proc_data_tag];
   assign resp_fetch = resp_hit && owner_is_fetch[mem2proc_data_tag];

   assign fetch_data_tag  = resp_fetch               ? mem2proc_data_tag : '0;
   assign dcache_data_tag = (resp_hit && !resp_fetch) ? mem2proc_data_tag : '0;
   assign resp_data       = mem2proc_data;

   always_ff @(posedge clock) begin
      if (reset) begin
         owner_valid       <= '0;
         owner_is_fetch    <= '0;
         fetch_outstanding <= '0;
         starve_cnt        <= '0;
      end else begin
         // Clear first so a same-cycle allocation of the same tag takes precedence.
         if (resp_hit)
            owner_valid[mem2proc_data_tag] <= 1'b0;
         if (alloc) begin
            owner_valid[mem2proc_transaction_tag]    <= 1'b1;
            owner_is_fetch[mem2proc_transaction_tag] <= ~dcache_grant;
         end

         if ((accepted && fetch_issue) && !resp_fetch) begin
            if (fetch_outstanding != TAG_W'(NUM_MEM_TAGS))
               fetch_outstanding <= fetch_outstanding + 1'b1;
         end else if (resp_fetch && !(accepted && fetch_issue)) begin
            if (fetch_outstanding != '0)
               fetch_outstanding <= fetch_outstanding - 1'b1;
         end

         starve_cnt <= dcache_grant ? starve_cnt + 1'b1 : '0;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        fetch_en;
   logic [31:0] fetch_addr;
   logic        fetch_grant;
   logic [3:0]  fetch_trans_tag;
   logic [3:0]  fetch_data_tag;
   logic        dcache_en;
   logic [1:0]  dcache_cmd;
   logic [31:0] dcache_addr;
   logic [63:0] dcache_wdata;
   logic        dcache_grant;
   logic [3:0]  dcache_trans_tag;
   logic [3:0]  dcache_data_tag;
   logic [63:0] resp_data;
   logic [1:0]  proc2mem_command;
   logic [31:0] proc2mem_addr;
   logic [63:0] proc2mem_data;
   logic [3:0]  mem2proc_transaction_tag;
   logic [3:0]  mem2proc_data_tag;
   logic [63:0] mem2proc_data;
   logic [3:0]  fetch_outstanding;

   int vectors     = 0;
   int miscompares = 0;

   mem_arbiter dut (
      .clock(clock), .reset(reset),
      .fetch_en(fetch_en), .fetch_addr(fetch_addr), .fetch_grant(fetch_grant),
      .fetch_trans_tag(fetch_trans_tag), .fetch_data_tag(fetch_data_tag),
      .dcache_en(dcache_en), .dcache_cmd(dcache_cmd), .dcache_addr(dcache_addr),
      .dcache_wdata(dcache_wdata), .dcache_grant(dcache_grant),
      .dcache_trans_tag(dcache_trans_tag), .dcache_data_tag(dcache_data_tag),
      .resp_data(resp_data), .proc2mem_command(proc2mem_command),
      .proc2mem_addr(proc2mem_addr), .proc2mem_data(proc2mem_data),
      .mem2proc_transaction_tag(mem2proc_transaction_tag),
      .mem2proc_data_tag(mem2proc_data_tag), .mem2proc_data(mem2proc_data),
      .fetch_outstanding(fetch_outstanding)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      fetch_en = 0; fetch_addr = '0;
      dcache_en = 0; dcache_cmd = 2'd0; dcache_addr = '0; dcache_wdata = '0;
      mem2proc_transaction_tag = '0; mem2proc_data_tag = '0; mem2proc_data = '0;
   endtask

   initial begin
      idle();
      reset = 1;
      tick(); tick();
      reset = 0;
      #1;
      chk("rst_fetch_grant", fetch_grant, 1);
      chk("rst_dcache_grant", dcache_grant, 0);
      chk("rst_cmd", proc2mem_command, 0);
      chk("rst_outstanding", fetch_outstanding, 0);
      chk("rst_fetch_ttag", fetch_trans_tag, 0);
      chk("rst_dcache_dtag", dcache_data_tag, 0);

      // fetch only
      fetch_en = 1; fetch_addr = 32'h100; mem2proc_transaction_tag = 4'd3; #1;
      chk("f_cmd", proc2mem_command, 1);
      chk("f_addr", proc2mem_addr, 32'h100);
      chk("f_data", proc2mem_data, 0);
      chk("f_ttag", fetch_trans_tag, 3);
      chk("f_dc_ttag", dcache_trans_tag, 0);
      tick(); idle(); #1;
      chk("f_out1", fetch_outstanding, 1);
      mem2proc_data_tag = 4'd3; mem2proc_data = 64'hdead_beef; #1;
      chk("f_dtag", fetch_data_tag, 3);
      chk("f_dc_dtag", dcache_data_tag, 0);
      chk("f_rdata", resp_data, 64'hdead_beef);
      tick(); idle(); #1;
      chk("f_out0", fetch_outstanding, 0);

      // contention: dcache wins over waiting fetch
      dcache_en = 1; dcache_cmd = 2'd1; dcache_addr = 32'h2000; fetch_en = 1; fetch_addr = 32'h140;
      mem2proc_transaction_tag = 4'd5; #1;
      chk("c_dgrant", dcache_grant, 1);
      chk("c_fgrant", fetch_grant, 0);
      chk("c_addr", proc2mem_addr, 32'h2000);
      chk("c_dttag", dcache_trans_tag, 5);
      chk("c_fttag", fetch_trans_tag, 0);
      tick(); idle(); tick();
      mem2proc_data_tag = 4'd5; #1;
      chk("c_ddtag", dcache_data_tag, 5);
      chk("c_fdtag", fetch_data_tag, 0);
      chk("c_out", fetch_outstanding, 0);
      tick(); idle();
      mem2proc_data_tag = 4'd5; #1;
      chk("c_stale_d", dcache_data_tag, 0);
      tick(); idle();

      // starvation: dcache held 10 cycles, tags 1..10
      for (int i = 0; i < 10; i++) begin
         dcache_en = 1; dcache_cmd = 2'd1; dcache_addr = 32'h3000 + i; fetch_en = 1; fetch_addr = 32'h200;
         mem2proc_transaction_tag = 4'(i + 1); #1;
         chk($sformatf("s_dgrant%0d", i), dcache_grant, (i % 5) != 4);
         chk($sformatf("s_fgrant%0d", i), fetch_grant, (i % 5) == 4);
         tick();
      end
      idle(); #1;
      chk("s_out", fetch_outstanding, 2);
      for (int t = 1; t <= 10; t++) begin
         mem2proc_data_tag = 4'(t); #1;
         chk($sformatf("s_fdtag%0d", t), fetch_data_tag, (t == 5 || t == 10) ? t : 0);
         chk($sformatf("s_ddtag%0d", t), dcache_data_tag, (t == 5 || t == 10) ? 0 : t);
         tick();
      end
      idle(); #1;
      chk("s_drained", fetch_outstanding, 0);

      // store: no table entry
      dcache_en = 1; dcache_cmd = 2'd2; dcache_addr = 32'h4000; dcache_wdata = 64'h1234;
      mem2proc_transaction_tag = 4'd7; #1;
      chk("st_cmd", proc2mem_command, 2);
      chk("st_data", proc2mem_data, 64'h1234);
      chk("st_ttag", dcache_trans_tag, 7);
      tick(); idle();
      mem2proc_data_tag = 4'd7; #1;
      chk("st_fdtag", fetch_data_tag, 0);
      chk("st_ddtag", dcache_data_tag, 0);
      tick(); idle(); #1;
      chk("st_out", fetch_outstanding, 0);

      // fetch cap: 8 loads on tags 1..8
      for (int i = 0; i < 8; i++) begin
         fetch_en = 1; fetch_addr = 32'h500 + 32'(i * 64); mem2proc_transaction_tag = 4'(i + 1); #1;
         chk($sformatf("cap_grant%0d", i), fetch_grant, 1);
         tick();
      end
      mem2proc_transaction_tag = 4'd9; #1;
      chk("cap_out8", fetch_outstanding, 8);
      chk("cap_nogrant", fetch_grant, 0);
      chk("cap_cmd", proc2mem_command, 0);
      chk("cap_ttag", fetch_trans_tag, 0);
      mem2proc_transaction_tag = 4'd0; mem2proc_data_tag = 4'd1; #1;
      chk("cap_resp", fetch_data_tag, 1);
      tick(); idle(); #1;
      chk("cap_regrant", fetch_grant, 1);
      chk("cap_out7", fetch_outstanding, 7);

      // same-cycle clear and allocate of tag 2 with inc/dec cancelling
      fetch_en = 1; fetch_addr = 32'h900; mem2proc_transaction_tag = 4'd2; mem2proc_data_tag = 4'd2; #1;
      chk("sc_dtag", fetch_data_tag, 2);
      tick(); idle(); #1;
      chk("sc_out7", fetch_outstanding, 7);
      mem2proc_data_tag = 4'd2; #1;
      chk("sc_realloc", fetch_data_tag, 2);
      tick(); idle(); #1;
      chk("sc_out6", fetch_outstanding, 6);

      // rejection: fetch then dcache retry
      fetch_en = 1; fetch_addr = 32'ha00; mem2proc_transaction_tag = 4'd0; #1;
      chk("rj_fcmd", proc2mem_command, 1);
      chk("rj_fttag", fetch_trans_tag, 0);
      tick(); idle(); #1;
      chk("rj_out", fetch_outstanding, 6);
      dcache_en = 1; dcache_cmd = 2'd1; dcache_addr = 32'h6000; #1;
      chk("rj_dttag0", dcache_trans_tag, 0);
      tick();
      mem2proc_transaction_tag = 4'd11; #1;
      chk("rj_retry_grant", dcache_grant, 1);
      chk("rj_dttag", dcache_trans_tag, 11);
      tick(); idle(); #1;
      chk("rj_out2", fetch_outstanding, 6);

      // reset with loads outstanding
      reset = 1; tick(); reset = 0; #1;
      chk("rr_out", fetch_outstanding, 0);
      mem2proc_data_tag = 4'd3; #1;
      chk("rr_fdtag3", fetch_data_tag, 0);
      chk("rr_ddtag3", dcache_data_tag, 0);
      tick();
      mem2proc_data_tag = 4'd11; #1;
      chk("rr_ddtag11", dcache_data_tag, 0);
      tick(); idle(); #1;
      chk("rr_out_nounder", fetch_outstanding, 0);
      chk("rr_fgrant", fetch_grant, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single memory port between the fetch stage (instruction-block prefetch/miss requests) and the data cache (loads/stores).
- Produces fetch's arbiter_signal, steers the command to memory, and hands the returned transaction tag to the winning requester.
- Keeps a per-tag ownership table so each data response (mem2proc_data_tag) reaches only the requester that issued it.
- Bounds fetch starvation and fetch's in-flight request count.

Parameters:
NUM_MEM_TAGS, `NUM_MEM_TAGS (15), number of memory transaction tags; tag 0 means none or rejected.
STARVE_LIMIT, 4, consecutive dcache-granted cycles after which one cycle is reserved for fetch.
FETCH_MAX_OUTSTANDING, 8, maximum fetch loads in flight.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high
fetch_en  input  1  fetch issuing a load this cycle; only valid while fetch_grant=1
fetch_addr  input  ADDR  fetch block address
fetch_grant  output  1  drives fetch arbiter_signal
fetch_trans_tag  output  MEM_TAG  memory tag for fetch's request; 0 when not fetch's cycle
fetch_data_tag  output  MEM_TAG  completed tag owned by fetch; else 0
dcache_en  input  1  dcache request; held until accepted
dcache_cmd  input  MEM_COMMAND  MEM_LOAD or MEM_STORE
dcache_addr  input  ADDR  dcache address
dcache_wdata  input  MEM_BLOCK  store data
dcache_grant  output  1  dcache owns the port this cycle
dcache_trans_tag  output  MEM_TAG  memory tag for dcache's request; 0 when not dcache's cycle
dcache_data_tag  output  MEM_TAG  completed tag owned by dcache; else 0
resp_data  output  MEM_BLOCK  mem2proc_data, broadcast to both requesters
proc2mem_command  output  MEM_COMMAND  MEM_NONE, MEM_LOAD or MEM_STORE
proc2mem_addr  output  ADDR  request address
proc2mem_data  output  MEM_BLOCK  store data
mem2proc_transaction_tag  input  MEM_TAG  tag for this cycle's command; 0 means rejected
mem2proc_data_tag  input  MEM_TAG  completed load tag; 0 means none
mem2proc_data  input  MEM_BLOCK  completed load data
fetch_outstanding  output  $clog2(NUM_MEM_TAGS+1)  fetch loads in flight (debug and verification)

Behaviour:
- Grant logic is combinational from registered state, dcache_en and dcache_cmd only. fetch_grant never depends on fetch_en, so fetch's comb loop is avoided.
- starve_force = (starve_cnt == STARVE_LIMIT).
- dcache_grant = dcache_en & ~starve_force.
- fetch_grant = ~dcache_grant & (fetch_outstanding < FETCH_MAX_OUTSTANDING).
- Command mux:
  - dcache_grant: cmd, addr and wdata come from dcache.
  - fetch_grant & fetch_en: MEM_LOAD with fetch_addr; proc2mem_data = 0.
  - otherwise: MEM_NONE, addr and data 0.
- accepted = (proc2mem_command != MEM_NONE) & (mem2proc_transaction_tag != 0).
- mem2proc_transaction_tag is forwarded unmodified to the granted requester's trans_tag output; the other requester gets 0.
- A rejected dcache request keeps dcache_en asserted and retries. Fetch retries through its own next-cycle logic.
- Ownership table: owner_valid[NUM_MEM_TAGS:1] plus owner_is_fetch[NUM_MEM_TAGS:1].
  - Accepted load: the entry for that tag is set on the next clock edge.
  - Accepted store: no entry is made, because stores return no data.
- Response routing (combinational):
  - If mem2proc_data_tag != 0 and owner_valid[tag], forward the tag to the owner's data_tag output; the other output is 0. The entry is cleared on the next edge.
  - If mem2proc_data_tag != 0 and the entry is invalid, the response is dropped: both data_tag outputs are 0.
  - resp_data = mem2proc_data always.
- Same-cycle clear and allocate of one tag: allocation wins and the entry stays valid with the new owner.
- fetch_outstanding:
  - +1 on an accepted fetch load; -1 on a fetch-owned response.
  - Both in the same cycle: unchanged.
  - Saturates at NUM_MEM_TAGS and never underflows.
- starve_cnt, width $clog2(STARVE_LIMIT+1):
  - Increments on each cycle with dcache_grant=1.
  - Resets to 0 on any cycle with dcache_grant=0, including the forced cycle.
  - The forced fetch slot is granted only if fetch_outstanding < FETCH_MAX_OUTSTANDING; the counter resets regardless.
- Fetch squash does not affect the arbiter. Fetch-owned responses still route to fetch, whose MSHRs absorb them.
- Reset:
  - owner table cleared; fetch_outstanding = 0; starve_cnt = 0.
  - Comb outputs with inputs idle: grants per the equations above (fetch_grant=1), tags 0, command MEM_NONE.
  - Responses arriving after reset for pre-reset tags hit invalid entries and are dropped.

Test Plan:
- Fetch only: fetch_en=1, addr 0x100, mem tag 3 -> fetch_trans_tag=3, dcache_trans_tag=0, fetch_outstanding 0→1. Later data_tag=3 -> fetch_data_tag=3, dcache_data_tag=0, count→0.
- Contention: dcache_en=1 load 0x2000 with fetch waiting -> dcache_grant=1, fetch_grant=0, proc2mem_addr=0x2000, tag 5 -> dcache_trans_tag=5. data_tag=5 routes to dcache only.
- Starvation: dcache_en held for 10 cycles, all accepted -> dcache_grant on cycles 0-3, fetch_grant on cycle 4, dcache again on 5-8, fetch on 9.
- Store: dcache MEM_STORE, tag 7 -> no table entry. A later spurious data_tag=7 -> both data_tag outputs 0.
- Fetch cap: 8 fetch loads accepted with no responses -> fetch_grant=0 while dcache idle. One fetch response -> fetch_grant=1 next cycle.
- Reject and reset: transaction_tag=0 -> no entry, counters unchanged, dcache retries. Reset with 3 loads outstanding -> table cleared; later responses on those tags dropped.
